simple_cpu_gen2: RTL and testbench

SIMPLE_CPU_GEN2 -- requirements
Module: simple_cpu_gen2

---
 rtl/simple_cpu_gen2.sv | 200 ++++++++++++++++++++
 tb/tb_simple_cpu_gen2.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_cpu_gen2.sv
// -----------------------------------------------------------------------------
// simple_cpu_gen2
//   Small multi-cycle CPU with a 16-bit instruction word, a register file of
//   NREG registers of DW bits, and separate request/acknowledge handshakes for
//   instruction fetch and data access. Each instruction is fetched (FETCH),
//   executed in one cycle (EXEC), and for loads/stores followed by a data
//   transfer (MEM). HALT parks the core until reset.
//
//   Instruction word: [15:12] op, [11:8] rd, [7:4] rm, [7:0] imm8 (signed).
//   Ops: 0 NOP, 1 ADD, 2 SUB, 3 LDI, 4 LD, 5 ST, 6 BEQZ, 7 JMP, 8 HALT,
//        9 MUL (only with SIMPLE_CPU_GEN2_MUL_EN), everything else illegal.
//
//   Build option: define SIMPLE_CPU_GEN2_MUL_EN to add op 9 (MUL, low DW bits
//   of rd*rm). Without it op 9 is an illegal opcode and no multiplier exists.
//
// Ports
//   clk, resetn            : clock (rising edge), async active-low reset
//   imem_req/addr/ack/rdata: instruction fetch handshake (addr = pc)
//   dmem_req/we/addr/wdata/ack/rdata : data handshake (addr = rm, wdata = rd)
//   halted                 : level, core is parked in HALT
//   illegal_op             : one-cycle pulse in EXEC of an undefined opcode
//   pc_o                   : current program counter
// -----------------------------------------------------------------------------
module simple_cpu_gen2 #(
  parameter int DW   = 8,
  parameter int NREG = 16,
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [DW-1:0]   dmem_addr,
  output logic [DW-1:0]   dmem_wdata,
  input  logic            dmem_ack,
  input  logic [DW-1:0]   dmem_rdata,
  output logic            halted,
  output logic            illegal_op,
  output logic [PC_W-1:0] pc_o
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_BEQZ = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'h8;
`ifdef SIMPLE_CPU_GEN2_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'h9;
`endif

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic [DW-1:0]   regs [NREG];

  logic            wr_en;
  logic [3:0]      wr_idx;
  logic [DW-1:0]   wr_data;

  // Decode of the latched instruction
  logic [3:0]             op, rd_idx, rm_idx;
  logic signed [7:0]      imm8;
  logic signed [DW-1:0]   imm_dw;
  logic signed [PC_W-1:0] imm_pc;
  logic [DW-1:0]          rd_val, rm_val;

  assign op     = instr_q[15:12];
  assign rd_idx = instr_q[11:8];
  assign rm_idx = instr_q[7:4];
  assign imm8   = instr_q[7:0];
  assign imm_dw = DW'(imm8);
  // Truncating to PC_W is correct because pc arithmetic wraps anyway.
  assign imm_pc = PC_W'(imm8);

  // Indices beyond the implemented register count read as zero.
  assign rd_val = (int'(rd_idx) < NREG) ? regs[rd_idx] : '0;
  assign rm_val = (int'(rm_idx) < NREG) ? regs[rm_idx] : '0;

`ifdef SIMPLE_CPU_GEN2_MUL_EN
  logic [DW-1:0] mul_res;
  assign mul_res = rd_val * rm_val;
`endif

  assign imem_addr = pc_q;
  assign pc_o      = pc_q;
  assign halted    = (state_q == HALT);

  // State, pc, instruction latch and register file
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= FETCH;
      pc_q    <= '0;
      instr_q <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      if (wr_en && (int'(wr_idx) < NREG)) regs[wr_idx] <= wr_data;
    end
  end

  // Next-state and outputs. Reads of rd/rm see the registered (pre-write)
  // values, so ADD r1,r1 uses the old r1.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    wr_en      = 1'b0;
    wr_idx     = rd_idx;
    wr_data    = '0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    illegal_op = 1'b0;

    case (state_q)
      FETCH: begin
        // Gated by resetn so the request drops the instant reset asserts.
        imem_req = resetn;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end

      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_q + PC_W'(1);
        case (op)
          OP_NOP: ;
          OP_ADD: begin
            wr_en   = 1'b1;
            wr_data = rd_val + rm_val;
          end
          OP_SUB: begin
            wr_en   = 1'b1;
            wr_data = rd_val - rm_val;
          end
          OP_LDI: begin
            wr_en   = 1'b1;
            wr_data = imm_dw;
          end
          OP_LD, OP_ST: begin
            pc_d    = pc_q;
            state_d = MEM;
          end
          OP_BEQZ: begin
            if (rd_val == '0) pc_d = pc_q + imm_pc;
          end
          OP_JMP: pc_d = pc_q + imm_pc;
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = HALT;
          end
`ifdef SIMPLE_CPU_GEN2_MUL_EN
          OP_MUL: begin
            wr_en   = 1'b1;
            wr_data = mul_res;
          end
`endif
          default: illegal_op = 1'b1;
        endcase
      end

      MEM: begin
        // Registers do not change while waiting, so addr/wdata stay stable.
        dmem_req   = 1'b1;
        dmem_we    = (op == OP_ST);
        dmem_addr  = rm_val;
        dmem_wdata = rd_val;
        if (dmem_ack) begin
          if (op == OP_LD) begin
            wr_en   = 1'b1;
            wr_data = dmem_rdata;
          end
          pc_d    = pc_q + PC_W'(1);
          state_d = FETCH;
        end
      end

      HALT: ;

      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_simple_cpu_gen2.sv
// -----------------------------------------------------------------------------
// tb_simple_cpu_gen2
//   Self-checking bench for simple_cpu_gen2 (DW=8, NREG=16, PC_W=8). An
//   instruction-level model tracks the expected phase, pc, registers and data
//   memory, and a single negedge process compares the DUT outputs against it
//   every cycle. Directed programs pin the model with literal results; random
//   programs with random handshake delays and stray acks exercise the rest.
// -----------------------------------------------------------------------------
module tb_simple_cpu_gen2;
  localparam int DW = 8, NREG = 16, PC_W = 8;

  logic            clk = 1'b0;
  logic            resetn = 1'b1;
  logic            imem_req, imem_ack;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0]   dmem_addr, dmem_wdata, dmem_rdata;
  logic            halted, illegal_op;
  logic [PC_W-1:0] pc_o;

  logic [15:0] prog [256];
  logic [7:0]  dmem_arr [256];

  // Handshake responder state
  int   icnt = 0, dcnt = 0, i_delay = 0, d_delay = 0;
  int   i_fix = 0, d_fix = 0, i_max = 0, d_max = 0;
  bit   spur_en = 1'b0;
  logic i_spur = 1'b0, d_spur = 1'b0;

  always #5 clk = ~clk;

  assign imem_rdata = prog[imem_addr];
  assign dmem_rdata = dmem_arr[dmem_addr];
  assign imem_ack   = imem_req ? (icnt >= i_delay) : i_spur;
  assign dmem_ack   = dmem_req ? (dcnt >= d_delay) : d_spur;

  simple_cpu_gen2 #(.DW(DW), .NREG(NREG), .PC_W(PC_W)) dut (
    .clk(clk), .resetn(resetn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .halted(halted), .illegal_op(illegal_op), .pc_o(pc_o)
  );

  // ---------------- bookkeeping ----------------
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int pick(input int fix, input int mx);
    return (fix >= 0) ? fix : int'($urandom_range(mx, 0));
  endfunction

  // ---------------- memory responder ----------------
  initial begin : responder
    bit hs_i, w_i, hs_d, w_d;
    forever begin
      @(negedge clk);
      hs_i = imem_req && imem_ack;
      w_i  = imem_req && !imem_ack;
      hs_d = dmem_req && dmem_ack;
      w_d  = dmem_req && !dmem_ack;
      if (hs_d && dmem_we) dmem_arr[dmem_addr] = dmem_wdata;
      @(posedge clk);
      #1;
      if (hs_i || !resetn) begin icnt = 0; i_delay = pick(i_fix, i_max); end
      else if (w_i) icnt++;
      if (hs_d || !resetn) begin dcnt = 0; d_delay = pick(d_fix, d_max); end
      else if (w_d) dcnt++;
      i_spur = spur_en && ($urandom_range(3, 0) == 0);
      d_spur = spur_en && ($urandom_range(3, 0) == 0);
    end
  end

  // ---------------- behavioural model + compare ----------------
  localparam int P_FETCH = 0, P_EXEC = 1, P_MEM = 2, P_HALT = 3;

  typedef struct { int cyc; int addr; } fent_t;
  fent_t fetch_log[$];
  int    illegal_log[$];
  int    dmem_run[$];

  int          m_phase = P_FETCH;
  int          m_pc = 0;
  int          m_regs [16];
  int          m_dmem [256];
  logic [15:0] m_instr = '0;
  int          cyc = 0, run_len = 0, hreq_cnt = 0;
  bit          prev_ireq = 1'b0;

  function automatic bit op_illegal(input int op);
`ifdef SIMPLE_CPU_GEN2_MUL_EN
    return op > 9;
`else
    return op > 8;
`endif
  endfunction

  // One instruction's architectural effect after its EXEC cycle.
  task automatic model_exec();
    int op, rd, rm, imm;
    op  = int'(m_instr[15:12]);
    rd  = int'(m_instr[11:8]);
    rm  = int'(m_instr[7:4]);
    imm = $signed(m_instr[7:0]);
    m_phase = P_FETCH;
    case (op)
      1: begin m_regs[rd] = (m_regs[rd] + m_regs[rm]) & 255; m_pc = (m_pc + 1) & 255; end
      2: begin m_regs[rd] = (m_regs[rd] - m_regs[rm]) & 255; m_pc = (m_pc + 1) & 255; end
      3: begin m_regs[rd] = imm & 255; m_pc = (m_pc + 1) & 255; end
      4, 5: m_phase = P_MEM;
      6: m_pc = (m_pc + ((m_regs[rd] == 0) ? imm : 1)) & 255;
      7: m_pc = (m_pc + imm) & 255;
      8: m_phase = P_HALT;
`ifdef SIMPLE_CPU_GEN2_MUL_EN
      9: begin m_regs[rd] = (m_regs[rd] * m_regs[rm]) & 255; m_pc = (m_pc + 1) & 255; end
`endif
      default: m_pc = (m_pc + 1) & 255;
    endcase
  endtask

  initial begin : compare
    int rd, rm;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        chk("reset_outputs",
            {imem_req, dmem_req, dmem_we, halted, illegal_op, imem_addr, dmem_addr, dmem_wdata, pc_o},
            64'd0);
        m_phase = P_FETCH; m_pc = 0; m_instr = '0;
        foreach (m_regs[i]) m_regs[i] = 0;
        cyc = 0; run_len = 0; hreq_cnt = 0; prev_ireq = 1'b0;
      end else begin
        if (imem_req && !prev_ireq) fetch_log.push_back('{cyc, int'(imem_addr)});
        prev_ireq = imem_req;
        rd = int'(m_instr[11:8]);
        rm = int'(m_instr[7:4]);
        chk("pc_o", pc_o, m_pc);
        case (m_phase)
          P_FETCH: begin
            chk("fetch_req", {imem_req, dmem_req, halted, illegal_op}, 4'b1000);
            chk("fetch_addr", imem_addr, m_pc);
            if (imem_ack) begin m_instr = prog[m_pc]; m_phase = P_EXEC; end
          end
          P_EXEC: begin
            chk("exec_req", {imem_req, dmem_req, halted}, 3'b000);
            chk("exec_illegal", illegal_op, op_illegal(int'(m_instr[15:12])));
            if (illegal_op) illegal_log.push_back(m_pc);
            model_exec();
          end
          P_MEM: begin
            chk("mem_req", {imem_req, dmem_req, halted, illegal_op}, 4'b0100);
            chk("mem_we", dmem_we, m_instr[15:12] == 4'h5);
            chk("mem_addr", dmem_addr, m_regs[rm]);
            chk("mem_wdata", dmem_wdata, m_regs[rd]);
            run_len++;
            if (dmem_ack) begin
              dmem_run.push_back(run_len);
              run_len = 0;
              if (m_instr[15:12] == 4'h5) m_dmem[m_regs[rm]] = m_regs[rd];
              else m_regs[rd] = m_dmem[m_regs[rm]];
              m_pc = (m_pc + 1) & 255;
              m_phase = P_FETCH;
            end
          end
          default: begin
            chk("halt_state", {halted, imem_req, dmem_req, illegal_op}, 4'b1000);
            if (imem_req) hreq_cnt++;
          end
        endcase
        cyc++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [15:0] rr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rm);
    return {op, rd, rm, 4'h0};
  endfunction
  function automatic logic [15:0] ri(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  function automatic int flog_addr(input int i);
    return (i < fetch_log.size()) ? fetch_log[i].addr : -1;
  endfunction
  function automatic int flog_cyc(input int i);
    return (i < fetch_log.size()) ? fetch_log[i].cyc : -1;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      prog[i] = 16'h0000; dmem_arr[i] = 8'h00; m_dmem[i] = 0;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    fetch_log.delete(); illegal_log.delete(); dmem_run.delete();
    resetn = 1'b1;
  endtask

  task automatic wait_halt(input string nm, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (halted) break;
      @(posedge clk);
    end
    #1;
    chk(nm, halted, 1'b1);
  endtask

  // ---------------- tests ----------------
  initial begin : main
    int exp4a [8];
    int exp4b [3];
    logic [15:0] w;
    exp4a = '{0, 1, 5, 4, 7, 8, 5, 6};
    exp4b = '{0, 254, 1};
    #1 resetn = 1'b0;

    // Basic sequence with zero-wait memory and fetch timing
    clear_mem(); i_fix = 0; d_fix = 0; spur_en = 1'b0;
    prog[0] = ri(3, 1, 8'd5); prog[1] = ri(3, 2, 8'd3); prog[2] = rr(2, 1, 2);
    prog[3] = ri(3, 4, 8'h40); prog[4] = rr(5, 1, 4); prog[5] = 16'h8000;
    do_reset(); wait_halt("t1_halt", 200);
    chk("t1_sub_result", dmem_arr[8'h40], 8'h02);
    chk("t1_fetch0", {flog_cyc(0), flog_addr(0)}, {32'd0, 32'd0});
    chk("t1_fetch1", {flog_cyc(1), flog_addr(1)}, {32'd2, 32'd1});
    chk("t1_fetch2", {flog_cyc(2), flog_addr(2)}, {32'd4, 32'd2});

    // Wrap-around arithmetic
    clear_mem();
    prog[0] = ri(3, 1, 8'h7F); prog[1] = ri(3, 2, 8'h01); prog[2] = rr(1, 1, 2);
    prog[3] = rr(2, 3, 2); prog[4] = ri(3, 4, 8'h41); prog[5] = rr(5, 1, 4);
    prog[6] = ri(3, 4, 8'h42); prog[7] = rr(5, 3, 4); prog[8] = 16'h8000;
    do_reset(); wait_halt("t2_halt", 200);
    chk("t2_add_wrap", dmem_arr[8'h41], 8'h80);
    chk("t2_sub_wrap", dmem_arr[8'h42], 8'hFF);

    // Delayed data acknowledge
    clear_mem(); d_fix = 3;
    prog[0] = ri(3, 4, 8'h20); prog[1] = ri(3, 5, 8'hAA); prog[2] = rr(5, 5, 4);
    prog[3] = rr(4, 6, 4); prog[4] = ri(3, 7, 8'h43); prog[5] = rr(5, 6, 7);
    prog[6] = 16'h8000;
    do_reset(); wait_halt("t3_halt", 200);
    chk("t3_st_cycles", (dmem_run.size() > 0) ? dmem_run[0] : -1, 4);
    chk("t3_ld_cycles", (dmem_run.size() > 1) ? dmem_run[1] : -1, 4);
    chk("t3_st_data", dmem_arr[8'h20], 8'hAA);
    chk("t3_ld_data", dmem_arr[8'h43], 8'hAA);
    d_fix = 0;

    // Branches
    clear_mem();
    prog[1] = ri(7, 0, 8'd4); prog[4] = ri(7, 0, 8'd3); prog[5] = ri(6, 0, 8'hFF);
    prog[6] = 16'h8000; prog[7] = ri(3, 0, 8'd1); prog[8] = ri(7, 0, 8'hFD);
    do_reset(); wait_halt("t4_halt", 200);
    chk("t4_fetch_count", fetch_log.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t4_fetch%0d", i), flog_addr(i), exp4a[i]);

    clear_mem();
    prog[0] = ri(7, 0, 8'hFE); prog[254] = ri(7, 0, 8'd3); prog[1] = 16'h8000;
    do_reset(); wait_halt("t4b_halt", 200);
    for (int i = 0; i < 3; i++) chk($sformatf("t4b_fetch%0d", i), flog_addr(i), exp4b[i]);

    // Illegal opcodes and optional multiply
    clear_mem();
    prog[3] = 16'hF000; prog[4] = ri(3, 1, 8'd2); prog[5] = ri(3, 2, 8'd3);
    prog[6] = 16'h9120; prog[7] = ri(3, 4, 8'h45); prog[8] = rr(5, 1, 4);
    prog[9] = 16'h8000;
    do_reset(); wait_halt("t5_halt", 200);
    chk("t5_illegal_pc", (illegal_log.size() > 0) ? illegal_log[0] : -1, 3);
    chk("t5_after_illegal", flog_addr(4), 4);
`ifdef SIMPLE_CPU_GEN2_MUL_EN
    chk("t5_illegal_count", illegal_log.size(), 1);
    chk("t5_mul_result", dmem_arr[8'h45], 8'h06);
`else
    chk("t5_illegal_count", illegal_log.size(), 2);
    chk("t5_op9_pc", (illegal_log.size() > 1) ? illegal_log[1] : -1, 6);
    chk("t5_op9_nop", dmem_arr[8'h45], 8'h02);
`endif

    // HALT persistence
    clear_mem(); prog[2] = 16'h8000;
    do_reset(); wait_halt("t6_halt", 100);
    repeat (20) @(posedge clk);
    #1;
    chk("t6_no_req_halted", hreq_cnt, 0);
    chk("t6_still_halted", halted, 1'b1);
    chk("t6_last_fetch", flog_addr(fetch_log.size() - 1), 2);

    // Reset during a pending fetch
    clear_mem(); i_fix = 0;
    do_reset();
    repeat (3) @(posedge clk);
    i_fix = 12;
    repeat (6) @(posedge clk);
    #2;
    chk("t6_pending_req", imem_req, 1'b1);
    resetn = 1'b0;
    #1;
    chk("t6_req_drop", {imem_req, pc_o}, 9'd0);
    i_fix = 0;
    do_reset();
    repeat (3) @(posedge clk);
    chk("t6_refetch", {flog_cyc(0), flog_addr(0)}, {32'd0, 32'd0});

    // Random programs with random delays and stray acknowledges
    i_fix = -1; d_fix = -1; i_max = 2; d_max = 3; spur_en = 1'b1;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 256; i++) begin
        w = 16'($urandom);
        if (w[15:12] == 4'h8 && $urandom_range(7, 0) != 0) w[15:12] = 4'h0;
        prog[i] = w;
        dmem_arr[i] = 8'($urandom);
        m_dmem[i] = int'(dmem_arr[i]);
      end
      do_reset();
      repeat (400) @(posedge clk);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
